// File: rtl/cfar_pkg.sv
// Shared types and default widths for the CFAR detector sample path.
// Used by the frame source, the detector and their benches.
package cfar_pkg;

  localparam int CFAR_INPUT_WIDTH = 16;
  localparam int CFAR_INDEX_WIDTH = 10;

  typedef enum logic [1:0] {
    SRC_IDLE   = 2'd0,
    SRC_STREAM = 2'd1,
    SRC_TAIL   = 2'd2,
    SRC_DONE   = 2'd3
  } src_state_t;

  typedef struct packed {
    logic [CFAR_INPUT_WIDTH-1:0] power;
    logic [CFAR_INDEX_WIDTH-1:0] index;
    logic                        eop;
    logic                        reverse;
  } cfar_sample_t;

endpackage

// File: rtl/cfar_frame_source_if.sv
// Sample stream between the frame source (master) and the CFAR detector (slave).
// Payload is qualified by input_valid and transfers on input_valid && out_ready.
interface cfar_frame_source_if
  import cfar_pkg::*;
#(
  parameter int INPUT_WIDTH = CFAR_INPUT_WIDTH,
  parameter int INDEX_WIDTH = CFAR_INDEX_WIDTH
);

  logic [INPUT_WIDTH-1:0] power_in;
  logic [INDEX_WIDTH-1:0] index_in;
  logic                   input_valid;
  logic                   eop_in;
  logic                   reverse;
  logic                   out_ready;

  modport master (
    output power_in,
    output index_in,
    output input_valid,
    output eop_in,
    output reverse,
    input  out_ready
  );

  modport slave (
    input  power_in,
    input  index_in,
    input  input_valid,
    input  eop_in,
    input  reverse,
    output out_ready
  );

endinterface

// File: rtl/cfar_skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered output stage.
// Latency: one cycle from in_vld to out_vld.
// Backpressure: in_rdy is registered (low only while the skid slot is occupied), full throughput sustained.
module cfar_skid_buffer #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;

  assign in_rdy = ~skid_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (out_rdy || !out_vld) begin
      // Output slot frees up: drain the skid entry first to keep order.
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_dat  <= skid_dat;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= in_vld;
        if (in_vld) out_dat <= in_dat;
      end
    end else if (in_vld && !skid_vld) begin
      skid_vld <= 1'b1;
      skid_dat <= in_dat;
    end
  end

endmodule

// File: rtl/cfar_frame_source.sv
// Frame-buffered sample source for the CFAR detector; optional descending order under CFAR_SRC_REVERSE_EN.
// Latency: start at edge N -> first input_valid at N+2; done 16 cycles after the eop transfer.
// Backpressure: out_ready stalls via a 2-entry skid stage; payload holds until accepted, no loss.
module cfar_frame_source
  import cfar_pkg::*;
#(
  parameter int INPUT_WIDTH = CFAR_INPUT_WIDTH,
  parameter int INDEX_WIDTH = CFAR_INDEX_WIDTH,
  parameter int TAIL_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic [INPUT_WIDTH-1:0] wr_data,
  input  logic [INDEX_WIDTH:0]   frame_len,
  input  logic                   start,
`ifdef CFAR_SRC_REVERSE_EN
  input  logic                   reverse_cfg,
`endif
  cfar_frame_source_if.master    smp,
  output logic                   busy,
  output logic                   done
);

  localparam int LEN_W   = INDEX_WIDTH + 1;
  localparam int DEPTH_N = 1 << INDEX_WIDTH;
  localparam int TAIL_W  = $clog2(TAIL_CYCLES + 1);
  localparam logic [LEN_W-1:0] DEPTH = {1'b1, {INDEX_WIDTH{1'b0}}};

  localparam logic [1:0] ST_IDLE   = SRC_IDLE;
  localparam logic [1:0] ST_STREAM = SRC_STREAM;
  localparam logic [1:0] ST_TAIL   = SRC_TAIL;
  localparam logic [1:0] ST_DONE   = SRC_DONE;

  typedef struct packed {
    logic [INPUT_WIDTH-1:0] power;
    logic [INDEX_WIDTH-1:0] index;
    logic                   eop;
    logic                   reverse;
  } sample_t;

  logic [1:0]             state_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       cnt_q;
  logic [LEN_W-1:0]       len_clamped;
  logic [TAIL_W-1:0]      tail_q;
  logic [INDEX_WIDTH-1:0] rd_addr;
  logic                   rev_flag;

  logic [INPUT_WIDTH-1:0] mem [0:DEPTH_N-1];
  logic [INPUT_WIDTH-1:0] rd_pwr;
  logic [INDEX_WIDTH-1:0] rd_idx;
  logic                   rd_eop;
  logic                   rd_vld;
  logic                   rd_issue;
  sample_t                rd_smp;
  sample_t                out_smp;
  logic                   skid_in_rdy;
  logic                   out_vld;
  logic                   last_xfer;

  assign len_clamped = (frame_len > DEPTH) ? DEPTH : frame_len;

`ifdef CFAR_SRC_REVERSE_EN
  logic rev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rev_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      rev_q <= reverse_cfg;
    end
  end

  assign rd_addr  = rev_q ? INDEX_WIDTH'(len_q - LEN_W'(1) - cnt_q) : cnt_q[INDEX_WIDTH-1:0];
  assign rev_flag = rev_q;
`else
  assign rd_addr  = cnt_q[INDEX_WIDTH-1:0];
  assign rev_flag = 1'b0;
`endif

  // A read may issue when the read register is empty or is being drained into the skid stage.
  assign rd_issue = (state_q == ST_STREAM) && (cnt_q != len_q) && (!rd_vld || skid_in_rdy);

  always_ff @(posedge clk) begin
    if (wr_en && state_q == ST_IDLE) mem[wr_addr] <= wr_data;
    if (rd_issue) rd_pwr <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
      rd_eop  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_q == ST_STREAM) || (state_q == ST_TAIL);
      done <= (state_q == ST_DONE);

      if (rd_issue) begin
        rd_vld <= 1'b1;
        rd_idx <= rd_addr;
        rd_eop <= (cnt_q == len_q - LEN_W'(1));
        cnt_q  <= cnt_q + LEN_W'(1);
      end else if (skid_in_rdy) begin
        rd_vld <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= len_clamped;
            cnt_q   <= '0;
            state_q <= (len_clamped == '0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (last_xfer) begin
            state_q <= ST_TAIL;
            tail_q  <= TAIL_W'(TAIL_CYCLES - 1);
          end
        end
        ST_TAIL: begin
          if (tail_q == '0) state_q <= ST_DONE;
          else              tail_q  <= tail_q - TAIL_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_smp         = '0;
    rd_smp.power   = rd_pwr;
    rd_smp.index   = rd_idx;
    rd_smp.eop     = rd_eop;
    rd_smp.reverse = rev_flag;
  end

  cfar_skid_buffer #(
    .WIDTH($bits(sample_t))
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rd_vld),
    .in_rdy  (skid_in_rdy),
    .in_dat  (rd_smp),
    .out_vld (out_vld),
    .out_rdy (smp.out_ready),
    .out_dat (out_smp)
  );

  assign last_xfer = out_vld && smp.out_ready && out_smp.eop;

  assign smp.input_valid = out_vld;
  assign smp.power_in    = out_smp.power;
  assign smp.index_in    = out_smp.index;
  assign smp.eop_in      = out_smp.eop;
  assign smp.reverse     = out_vld & out_smp.reverse;

endmodule

// File: tb/tb_cfar_frame_source.sv
// Directed bench for cfar_frame_source: ordering, latency, tail timing, backpressure, boundaries, abort.
// Build with CFAR_SRC_REVERSE_EN to include the descending-order frame.
module tb_cfar_frame_source;
  import cfar_pkg::*;

  localparam int IW    = CFAR_INDEX_WIDTH;
  localparam int DW    = CFAR_INPUT_WIDTH;
  localparam int LW    = IW + 1;
  localparam int TAIL  = 15;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [IW:0]   frame_len;
  logic          start;
  logic          busy;
  logic          done;
`ifdef CFAR_SRC_REVERSE_EN
  logic          rev_cfg;
`endif

  always #5 clk = ~clk;

  cfar_frame_source_if #(.INPUT_WIDTH(DW), .INDEX_WIDTH(IW)) smp ();

  cfar_frame_source #(
    .INPUT_WIDTH (DW),
    .INDEX_WIDTH (IW),
    .TAIL_CYCLES (TAIL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_len   (frame_len),
    .start       (start),
`ifdef CFAR_SRC_REVERSE_EN
    .reverse_cfg (rev_cfg),
`endif
    .smp         (smp),
    .busy        (busy),
    .done        (done)
  );

  logic [DW-1:0] model_mem [DEPTH];
  int n_chk = 0;
  int n_err = 0;

  // Per-frame results filled by run_frame.
  int r_n, r_seq_err, r_fv, r_first, r_last, r_done, r_stab, r_rev_err, r_busy_done, r_eop_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr_mem(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = IW'(a);
    wr_data = DW'(d);
    model_mem[a] = DW'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge N = iteration 0 -> 1).
  task automatic run_frame(input int flen, input bit rev, input bit rnd, input int abort_at, input bit inject);
    int           leff;
    int           exp_idx;
    bit           rev_exp;
    bit           prev_vld;
    bit           prev_rdy;
    bit           eop_stalled;
    bit           rdy;
    cfar_sample_t cur;
    cfar_sample_t prev;
    leff = (flen > DEPTH) ? DEPTH : flen;
`ifdef CFAR_SRC_REVERSE_EN
    rev_exp = rev;
    rev_cfg = rev;
`else
    rev_exp = 1'b0;
    if (rev) $display("note: reverse request ignored in this build");
`endif
    r_n = 0; r_seq_err = 0; r_fv = -1; r_first = -1; r_last = -1; r_done = -1;
    r_stab = 0; r_rev_err = 0; r_busy_done = -1; r_eop_cnt = 0;
    prev_vld = 1'b0; prev_rdy = 1'b0; eop_stalled = 1'b0; prev = '0;
    start     = 1'b1;
    frame_len = LW'(flen);
    for (int it = 1; it < 4000; it++) begin
      @(negedge clk);
      if (it == 1) start = 1'b0;
      if (inject && it == 10) begin
        start = 1'b1; frame_len = LW'(5);
        wr_en = 1'b1; wr_addr = IW'(50); wr_data = 16'hBEEF;
      end
      if (inject && it == 11) begin
        start = 1'b0; wr_en = 1'b0;
      end
      cur = '{power: smp.power_in, index: smp.index_in, eop: smp.eop_in, reverse: smp.reverse};
      if (!smp.input_valid && smp.reverse) r_rev_err++;
      if (prev_vld && !prev_rdy && (!smp.input_valid || cur != prev)) r_stab++;
      if (smp.input_valid && r_fv < 0) r_fv = it;
      if (done) begin
        r_done      = it;
        r_busy_done = int'(busy);
        break;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd && smp.input_valid && smp.eop_in && !eop_stalled) begin
        rdy = 1'b0;
        eop_stalled = 1'b1;
      end
      smp.out_ready = rdy;
      if (smp.input_valid && rdy) begin
        if (r_first < 0) r_first = it;
        r_last = it;
        if (r_n >= leff) begin
          r_seq_err++;
        end else begin
          exp_idx = rev_exp ? (leff - 1 - r_n) : r_n;
          if (cur.index != IW'(exp_idx) || cur.power != model_mem[exp_idx] ||
              cur.eop != (r_n == leff - 1)) r_seq_err++;
        end
        if (cur.reverse != rev_exp) r_rev_err++;
        if (cur.eop) r_eop_cnt++;
        r_n++;
        if (abort_at != 0 && r_n == abort_at) break;
      end
      prev_vld = smp.input_valid;
      prev_rdy = rdy;
      prev     = cur;
    end
  endtask

  initial begin
    int idle_bad;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    frame_len = '0; start = 1'b0; smp.out_ready = 1'b0;
`ifdef CFAR_SRC_REVERSE_EN
    rev_cfg = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", smp.input_valid, 0);
    check("rst_power", smp.power_in, 0);
    check("rst_index", smp.index_in, 0);
    check("rst_eop",   smp.eop_in, 0);
    check("rst_rev",   smp.reverse, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) wr_mem(a, a);

    // Full-depth ascending frame, out_ready held high.
    run_frame(1024, 0, 0, 0, 0);
    check("asc_count",   r_n, 1024);
    check("asc_seq",     r_seq_err, 0);
    check("asc_latency", r_fv, 3);
    check("asc_contig",  r_last - r_first + 1, 1024);
    check("asc_eop_cnt", r_eop_cnt, 1);
    check("asc_done_gap", r_done - r_last - 1, TAIL + 1);
    check("asc_busy_at_done", r_busy_done, 0);
    check("asc_rev", r_rev_err, 0);

    // Random backpressure; last write lands one edge before start.
    wr_mem(36, 16'h1234);
    run_frame(37, 0, 1, 0, 0);
    check("bp_count",  r_n, 37);
    check("bp_seq",    r_seq_err, 0);
    check("bp_stable", r_stab, 0);
    check("bp_eop_cnt", r_eop_cnt, 1);
    check("bp_done_gap", r_done - r_last - 1, TAIL + 1);

`ifdef CFAR_SRC_REVERSE_EN
    run_frame(8, 1, 0, 0, 0);
    check("rev_count", r_n, 8);
    check("rev_seq",   r_seq_err, 0);
    check("rev_flag",  r_rev_err, 0);
    check("rev_eop_cnt", r_eop_cnt, 1);
`endif

    run_frame(0, 0, 0, 0, 0);
    check("len0_count", r_n, 0);
    check("len0_done",  r_done, 2);
    check("len0_novalid", r_fv, -1);

    run_frame(1, 0, 0, 0, 0);
    check("len1_count", r_n, 1);
    check("len1_seq",   r_seq_err, 0);
    check("len1_eop_cnt", r_eop_cnt, 1);
    check("len1_latency", r_fv, 3);

    run_frame(2000, 0, 0, 0, 0);
    check("clamp_count", r_n, 1024);
    check("clamp_seq",   r_seq_err, 0);

    // start/wr_en pulsed mid-stream must be ignored.
    run_frame(64, 0, 0, 0, 1);
    check("inj_count", r_n, 64);
    check("inj_seq",   r_seq_err, 0);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (smp.input_valid || busy || done) idle_bad++;
    end
    check("inj_no_restart", idle_bad, 0);

    // Reset after 100 transfers aborts the frame.
    run_frame(1024, 0, 0, 100, 0);
    check("abort_count", r_n, 100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", smp.input_valid, 0);
    check("abort_power", smp.power_in, 0);
    check("abort_index", smp.index_in, 0);
    check("abort_eop",   smp.eop_in, 0);
    check("abort_busy",  busy, 0);
    reset = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (smp.input_valid || done || busy) idle_bad++;
    end
    check("abort_quiet", idle_bad, 0);
    run_frame(1024, 0, 0, 0, 0);
    check("post_abort_count", r_n, 1024);
    check("post_abort_seq",   r_seq_err, 0);
    check("post_abort_latency", r_fv, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
